// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: datapath widths, FSM
// state encodings, fault codes, the NOP word and the default reset PC.
package ifu_pkg;

    localparam int unsigned ysyx_23060251_xlen     = 32;
    localparam int unsigned ysyx_23060251_inst_bus = 32;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_ACCESS   = 2'b01,
        FAULT_MISALIGN = 2'b10
    } fault_e;

    localparam logic [ysyx_23060251_inst_bus-1:0] INST_NOP         = 32'h0000_0013;
    localparam logic [ysyx_23060251_xlen-1:0]     DEFAULT_RESET_PC = 32'h8000_0000;

    function automatic logic [ysyx_23060251_xlen-1:0] seq_pc(
        input logic [ysyx_23060251_xlen-1:0] pc
    );
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/ifu_if.sv
// Fetch-side bus bundle: redirect input, instruction-memory request/response
// channel and the instruction handshake towards idu.
interface ifu_if;
    import ifu_pkg::*;

    logic                              redirect_valid_i;
    logic [ysyx_23060251_xlen-1:0]     redirect_pc_i;
    logic                              req_valid_o;
    logic                              req_ready_i;
    logic [ysyx_23060251_xlen-1:0]     req_addr_o;
    logic                              rsp_valid_i;
    logic [ysyx_23060251_inst_bus-1:0] rsp_data_i;
    logic                              rsp_err_i;
    logic                              inst_valid_o;
    logic                              inst_ready_i;
    logic [ysyx_23060251_inst_bus-1:0] inst_o;
    logic [ysyx_23060251_xlen-1:0]     pc_o;
    logic [1:0]                        fault_o;

    modport master (
        input  redirect_valid_i, redirect_pc_i, req_ready_i,
               rsp_valid_i, rsp_data_i, rsp_err_i, inst_ready_i,
        output req_valid_o, req_addr_o, inst_valid_o, inst_o, pc_o, fault_o
    );

    modport slave (
        output redirect_valid_i, redirect_pc_i, req_ready_i,
               rsp_valid_i, rsp_data_i, rsp_err_i, inst_ready_i,
        input  req_valid_o, req_addr_o, inst_valid_o, inst_o, pc_o, fault_o
    );

endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding imem read, redirect with stale-response
// kill. Optional PC alignment check enabled by YSYX_23060251_IFU_MISALIGN_CHECK_EN.
module ifu
    import ifu_pkg::*;
#(
    parameter logic [ysyx_23060251_xlen-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input logic   clk,
    input logic   rst,
    ifu_if.master bus
);

    state_e                            state;
    logic [ysyx_23060251_xlen-1:0]     pc;
    logic                              kill;
    logic [ysyx_23060251_inst_bus-1:0] inst_q;
    logic [ysyx_23060251_xlen-1:0]     pc_q;
    fault_e                            fault_q;
    logic                              misaligned;

`ifdef YSYX_23060251_IFU_MISALIGN_CHECK_EN
    assign misaligned = |pc[1:0];
`else
    assign misaligned = 1'b0;
`endif

    assign bus.req_valid_o  = ~rst & (state == S_REQ) & ~misaligned;
    assign bus.req_addr_o   = pc;
    assign bus.inst_valid_o = ~rst & (state == S_HOLD) & ~bus.redirect_valid_i;
    assign bus.inst_o       = inst_q;
    assign bus.pc_o         = pc_q;
    assign bus.fault_o      = fault_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_REQ;
            pc      <= RESET_PC;
            kill    <= 1'b0;
            inst_q  <= '0;
            pc_q    <= '0;
            fault_q <= FAULT_NONE;
        end else begin
            unique case (state)
                S_REQ: begin
                    if (misaligned) begin
                        if (bus.redirect_valid_i) begin
                            pc <= bus.redirect_pc_i;
                        end else begin
                            state   <= S_HOLD;
                            inst_q  <= INST_NOP;
                            pc_q    <= pc;
                            fault_q <= FAULT_MISALIGN;
                        end
                    end else if (bus.req_ready_i) begin
                        state <= S_WAIT;
                        // request already accepted for the old PC: its response must be dropped
                        if (bus.redirect_valid_i) begin
                            pc   <= bus.redirect_pc_i;
                            kill <= 1'b1;
                        end
                    end else if (bus.redirect_valid_i) begin
                        pc <= bus.redirect_pc_i;
                    end
                end

                S_WAIT: begin
                    if (bus.redirect_valid_i) begin
                        pc <= bus.redirect_pc_i;
                        if (bus.rsp_valid_i) begin
                            state <= S_REQ;
                            kill  <= 1'b0;
                        end else begin
                            kill <= 1'b1;
                        end
                    end else if (bus.rsp_valid_i) begin
                        if (kill) begin
                            kill  <= 1'b0;
                            state <= S_REQ;
                        end else begin
                            inst_q  <= bus.rsp_data_i;
                            pc_q    <= pc;
                            fault_q <= bus.rsp_err_i ? FAULT_ACCESS : FAULT_NONE;
                            state   <= S_HOLD;
                        end
                    end
                end

                S_HOLD: begin
                    if (bus.redirect_valid_i) begin
                        pc    <= bus.redirect_pc_i;
                        state <= S_REQ;
                    end else if (bus.inst_ready_i) begin
                        pc    <= seq_pc(pc);
                        state <= S_REQ;
                    end
                end

                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: directed vector table, misalignment sequence and a randomized
// run checked against a fetch-stream reference model.
module tb_ifu;

    localparam logic [31:0] B = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    ifu_if bus();

    ifu #(.RESET_PC(32'h8000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rdy;
        bit          rv;
        logic [31:0] rd;
        bit          re;
        bit          ir;
        bit          xv;
        logic [31:0] xpc;
        bit          erv;
        logic [31:0] era;
        bit          eiv;
        logic [31:0] epc;
        logic [31:0] ein;
        logic [1:0]  ef;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic v(input bit rdy, input bit rv, input logic [31:0] rd, input bit re,
                     input bit ir, input bit xv, input logic [31:0] xpc,
                     input bit erv, input logic [31:0] era, input bit eiv,
                     input logic [31:0] epc, input logic [31:0] ein, input logic [1:0] ef);
        vec_t r;
        r.rdy = rdy; r.rv = rv; r.rd = rd; r.re = re; r.ir = ir; r.xv = xv; r.xpc = xpc;
        r.erv = erv; r.era = era; r.eiv = eiv; r.epc = epc; r.ein = ein; r.ef = ef;
        tbl.push_back(r);
    endtask

    task automatic drive(input bit rdy, input bit rv, input logic [31:0] rd, input bit re,
                         input bit ir, input bit xv, input logic [31:0] xpc);
        bus.req_ready_i      = rdy;
        bus.rsp_valid_i      = rv;
        bus.rsp_data_i       = rd;
        bus.rsp_err_i        = re;
        bus.inst_ready_i     = ir;
        bus.redirect_valid_i = xv;
        bus.redirect_pc_i    = xpc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic bit merr(input logic [31:0] a);
        return a[5:2] == 4'h3;
    endfunction

    // reference model state for the random phase
    logic [31:0] exp_pc;
    bit          outst;
    logic [31:0] out_addr;
    int unsigned cnt;
    bit          prev_req_hold;
    bit          prev_iv_hold;
    int          gap;
    int          deliveries;

    initial begin
        rst = 1'b1;
        drive(0, 0, '0, 0, 0, 0, '0);
        tick();
        tick();
        chk("rst_req_valid", 32'(bus.req_valid_o), 32'd0);
        chk("rst_inst_valid", 32'(bus.inst_valid_o), 32'd0);
        chk("rst_req_addr", bus.req_addr_o, 32'h8000_0000);
        chk("rst_pc_o", bus.pc_o, 32'h0);
        chk("rst_inst_o", bus.inst_o, 32'h0);
        chk("rst_fault_o", 32'(bus.fault_o), 32'd0);
        rst = 1'b0;

        // rdy rv data err ir xv xpc | erv era eiv epc inst fault
        v(1,0,'0,0,1,0,'0,          1,B,0,'0,'0,0);
        v(1,1,32'hA000_0000,0,1,0,'0, 0,'0,0,'0,'0,0);
        v(1,0,'0,0,1,0,'0,          0,'0,1,B,32'hA000_0000,0);
        v(1,0,'0,0,1,0,'0,          1,B+4,0,'0,'0,0);
        v(1,1,32'hA000_0001,0,1,0,'0, 0,'0,0,'0,'0,0);
        v(1,0,'0,0,1,0,'0,          0,'0,1,B+4,32'hA000_0001,0);
        v(1,0,'0,0,1,0,'0,          1,B+8,0,'0,'0,0);
        v(1,1,32'hDEAD_BEEF,1,1,0,'0, 0,'0,0,'0,'0,0);
        v(1,0,'0,0,1,0,'0,          0,'0,1,B+8,32'hDEAD_BEEF,2'b01);
        v(1,0,'0,0,1,0,'0,          1,B+32'hC,0,'0,'0,0);
        v(1,1,32'hA000_0003,0,1,0,'0, 0,'0,0,'0,'0,0);
        for (int i = 0; i < 5; i++)
            v(1,0,'0,0,0,0,'0,      0,'0,1,B+32'hC,32'hA000_0003,0);
        v(1,0,'0,0,1,0,'0,          0,'0,1,B+32'hC,32'hA000_0003,0);
        v(1,0,'0,0,1,0,'0,          1,B+32'h10,0,'0,'0,0);
        v(1,0,'0,0,1,1,B+32'h100,   0,'0,0,'0,'0,0);
        v(1,0,'0,0,1,0,'0,          0,'0,0,'0,'0,0);
        v(1,0,'0,0,1,0,'0,          0,'0,0,'0,'0,0);
        v(1,1,32'hBAD0_BAD0,0,1,0,'0, 0,'0,0,'0,'0,0);
        v(1,0,'0,0,1,0,'0,          1,B+32'h100,0,'0,'0,0);
        v(1,1,32'hA000_0005,0,1,1,B+32'h200, 0,'0,0,'0,'0,0);
        v(1,0,'0,0,1,0,'0,          1,B+32'h200,0,'0,'0,0);
        v(1,1,32'hA000_0006,0,1,0,'0, 0,'0,0,'0,'0,0);
        v(1,0,'0,0,1,0,'0,          0,'0,1,B+32'h200,32'hA000_0006,0);
        v(1,0,'0,0,1,0,'0,          1,B+32'h204,0,'0,'0,0);
        v(1,1,32'hA000_0007,0,1,0,'0, 0,'0,0,'0,'0,0);
        v(1,0,'0,0,1,1,B+32'h300,   0,'0,0,'0,'0,0);
        v(0,0,'0,0,1,1,B+32'h102,   1,B+32'h300,0,'0,'0,0);

        foreach (tbl[i]) begin
            drive(tbl[i].rdy, tbl[i].rv, tbl[i].rd, tbl[i].re, tbl[i].ir, tbl[i].xv, tbl[i].xpc);
            #1;
            chk($sformatf("row%0d req_valid", i), 32'(bus.req_valid_o), 32'(tbl[i].erv));
            if (tbl[i].erv)
                chk($sformatf("row%0d req_addr", i), bus.req_addr_o, tbl[i].era);
            chk($sformatf("row%0d inst_valid", i), 32'(bus.inst_valid_o), 32'(tbl[i].eiv));
            if (tbl[i].eiv) begin
                chk($sformatf("row%0d pc_o", i), bus.pc_o, tbl[i].epc);
                chk($sformatf("row%0d inst_o", i), bus.inst_o, tbl[i].ein);
                chk($sformatf("row%0d fault_o", i), 32'(bus.fault_o), 32'(tbl[i].ef));
            end
            tick();
        end

        // PC is now 8000_0102 in the request state
`ifdef YSYX_23060251_IFU_MISALIGN_CHECK_EN
        drive(1, 0, '0, 0, 0, 0, '0);
        #1;
        chk("mis_no_req", 32'(bus.req_valid_o), 32'd0);
        tick();
        #1;
        chk("mis_inst_valid", 32'(bus.inst_valid_o), 32'd1);
        chk("mis_inst_o", bus.inst_o, 32'h0000_0013);
        chk("mis_pc_o", bus.pc_o, 32'h8000_0102);
        chk("mis_fault_o", 32'(bus.fault_o), 32'd2);
        drive(1, 0, '0, 0, 0, 1, B + 32'h400);
        #1;
        chk("mis_redirect_iv", 32'(bus.inst_valid_o), 32'd0);
        tick();
        drive(1, 0, '0, 0, 0, 0, '0);
        #1;
        chk("mis_recover_rv", 32'(bus.req_valid_o), 32'd1);
        chk("mis_recover_addr", bus.req_addr_o, B + 32'h400);
        tick();
`else
        drive(1, 0, '0, 0, 0, 0, '0);
        #1;
        chk("mis_req_valid", 32'(bus.req_valid_o), 32'd1);
        chk("mis_req_addr", bus.req_addr_o, 32'h8000_0102);
        tick();
        drive(0, 1, 32'hA000_0009, 0, 0, 0, '0);
        #1;
        chk("mis_wait_rv", 32'(bus.req_valid_o), 32'd0);
        tick();
        drive(0, 0, '0, 0, 1, 0, '0);
        #1;
        chk("mis_inst_valid", 32'(bus.inst_valid_o), 32'd1);
        chk("mis_pc_o", bus.pc_o, 32'h8000_0102);
        chk("mis_inst_o", bus.inst_o, 32'hA000_0009);
        chk("mis_fault_o", 32'(bus.fault_o), 32'd0);
        tick();
        drive(0, 0, '0, 0, 0, 0, '0);
        #1;
        chk("mis_next_addr", bus.req_addr_o, 32'h8000_0106);
        tick();
`endif

        // reset from an arbitrary state, then randomized run
        rst = 1'b1;
        drive(0, 0, '0, 0, 1, 0, '0);
        #1;
        chk("rst2_req_valid", 32'(bus.req_valid_o), 32'd0);
        chk("rst2_inst_valid", 32'(bus.inst_valid_o), 32'd0);
        tick();
        rst = 1'b0;

        exp_pc        = 32'h8000_0000;
        outst         = 1'b0;
        out_addr      = '0;
        cnt           = 0;
        prev_req_hold = 1'b0;
        prev_iv_hold  = 1'b0;
        gap           = 0;
        deliveries    = 0;

        for (int c = 0; c < 3000; c++) begin
            bit          rdy, rv, ir, xv;
            logic [31:0] xpc, rd;
            bit          re;
            rv = 1'b0;
            rd = $urandom;
            re = 1'b0;
            if (outst) begin
                if (cnt == 0) begin
                    rv = 1'b1;
                    rd = mem(out_addr);
                    re = merr(out_addr);
                end else begin
                    cnt--;
                end
            end
            rdy = $urandom_range(0, 3) != 0;
            ir  = $urandom_range(0, 2) != 0;
            xv  = $urandom_range(0, 14) == 0;
            if ($urandom_range(0, 3) == 0)
                xpc = 32'hFFFF_FFF8;
            else
                xpc = B + ($urandom_range(0, 255) << 2);
            drive(rdy, rv, rd, re, ir, xv, xpc);
            #1;

            if (bus.req_valid_o) begin
                chk("rnd_req_addr", bus.req_addr_o, exp_pc);
                chk("rnd_single_outstanding", 32'(outst), 32'd0);
            end
            if (prev_req_hold)
                chk("rnd_req_held", 32'(bus.req_valid_o), 32'd1);
            if (xv)
                chk("rnd_iv_during_redirect", 32'(bus.inst_valid_o), 32'd0);
            if (bus.inst_valid_o) begin
                chk("rnd_pc_o", bus.pc_o, exp_pc);
                chk("rnd_inst_o", bus.inst_o, mem(bus.pc_o));
                chk("rnd_fault_o", 32'(bus.fault_o), merr(bus.pc_o) ? 32'd1 : 32'd0);
            end
            if (prev_iv_hold && !xv)
                chk("rnd_inst_held", 32'(bus.inst_valid_o), 32'd1);

            if (bus.req_valid_o || bus.inst_valid_o) gap = 0;
            else gap++;
            if (gap > 12) begin
                chk("rnd_progress_timeout", 32'(gap), 32'd0);
                break;
            end

            prev_req_hold = bus.req_valid_o && !rdy && !xv;
            prev_iv_hold  = bus.inst_valid_o && !ir && !xv;
            if (rv) outst = 1'b0;
            if (bus.req_valid_o && rdy) begin
                outst    = 1'b1;
                out_addr = bus.req_addr_o;
                cnt      = $urandom_range(0, 3);
            end
            if (xv) begin
                exp_pc = xpc;
            end else if (bus.inst_valid_o && ir) begin
                exp_pc = exp_pc + 32'd4;
                deliveries++;
            end
            tick();
        end
        chk("rnd_deliveries_min", 32'(deliveries >= 100), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
